// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write result, post-reset hardware clear and range checking.
module sdp_ram_be #(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 4,
  parameter  int DEPTH    = 16,
  parameter  int RD_LAT   = 1,
  parameter  int RDW_MODE = 0,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  // Handshake: there is no back-pressure. A request is taken on a rising edge
  // when the RAM is out of its clear phase (busy=0), en=1 and wr_en/rd_en=1;
  // rd_valid is a one-cycle qualifier for rd_data and cannot be stalled.

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                clr_we;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_acc, rd_acc, wr_ok, rd_ok;
  logic [DATA_W-1:0]   rd_word;

  logic                s1_valid_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                err_pend_q, addr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_C) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  assign wr_acc = (state_q == ST_RUN) && en && wr_en;
  assign rd_acc = (state_q == ST_RUN) && en && rd_en;
  assign wr_ok  = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_C);

  // Storage is not reset; the clear phase zeroes it one word per edge.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc && wr_ok) begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr_be[k]) mem_q[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Old-data mode falls out of reading the array before the edge; new-data
  // mode forwards the enabled write bytes over the stored word.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem_q[rd_addr];
      if (RDW_MODE == 1 && wr_acc && wr_ok && wr_addr == rd_addr) begin
        for (int k = 0; k < BE_W; k++) begin
          if (wr_be[k]) rd_word[8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_pend_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) s1_data_q <= rd_word;
      if (RD_LAT == 1) begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= rd_word;
      end else begin
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) rd_data_q <= s1_data_q;
      end
      err_pend_q <= (wr_acc && !wr_ok) || (rd_acc && !rd_ok);
      addr_err_q <= err_pend_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances with contrasting parameters share one
// stimulus stream and are checked each cycle against an array/queue model.
module tb_sdp_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b, addr_err_a, addr_err_b;

  always #5 clk = ~clk;

  sdp_ram_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .addr_err(addr_err_a));

  sdp_ram_be #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .addr_err(addr_err_b));

  // Reference model
  typedef struct {
    int          inst;
    int          due;
    bit          is_err;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] mem_m [2][16];
  int          clear_left [2];
  logic [31:0] last_m [2];
  int          depth_m [2] = '{16, 12};
  int          lat_m   [2] = '{1, 2};
  int          rdw_m   [2] = '{0, 1};
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      clear_left[i] = depth_m[i];
      last_m[i] = '0;
      for (int a = 0; a < 16; a++) mem_m[i][a] = '0;
    end
  endtask

  task automatic model_edge();
    bit          wok, rok;
    logic [31:0] w;
    cyc++;
    if (rst) return;
    for (int i = 0; i < 2; i++) begin
      if (clear_left[i] > 0) begin
        clear_left[i]--;
      end else if (en) begin
        wok = wr_en && (int'(wr_addr) < depth_m[i]);
        rok = rd_en && (int'(rd_addr) < depth_m[i]);
        if (rd_en) begin
          w = rok ? mem_m[i][rd_addr] : 32'h0;
          if (rdw_m[i] == 1 && wok && wr_addr == rd_addr) w = merge(w, wr_data, wr_be);
          exp_q.push_back('{inst: i, due: cyc + lat_m[i] - 1, is_err: 1'b0, data: w});
        end
        if ((wr_en && !wok) || (rd_en && !rok))
          exp_q.push_back('{inst: i, due: cyc + 1, is_err: 1'b1, data: 32'h0});
        if (wok) mem_m[i][wr_addr] = merge(mem_m[i][wr_addr], wr_data, wr_be);
      end
    end
  endtask

  task automatic check_all();
    logic ev, ee;
    string nm;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "a" : "b";
      ev = 1'b0;
      ee = 1'b0;
      foreach (exp_q[j]) begin
        if (exp_q[j].inst == i && exp_q[j].due == cyc) begin
          if (exp_q[j].is_err) ee = 1'b1;
          else begin
            ev = 1'b1;
            last_m[i] = exp_q[j].data;
          end
        end
      end
      chk({"rd_valid_", nm}, 32'((i == 0) ? rd_valid_a : rd_valid_b), 32'(ev));
      chk({"rd_data_", nm},  (i == 0) ? rd_data_a : rd_data_b, last_m[i]);
      chk({"busy_", nm},     32'((i == 0) ? busy_a : busy_b), 32'(clear_left[i] > 0));
      chk({"addr_err_", nm}, 32'((i == 0) ? addr_err_a : addr_err_b), 32'(ee));
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].due <= cyc) exp_q.delete(j);
  endtask

  // Driver tasks: inputs change only after the falling edge checks.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_valid_b", 32'(rd_valid_b), 32'd0);
    chk("rst_data_a", rd_data_a, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d, logic [3:0] be);
    wr_en = 1'b1; rd_en = 1'b0; wr_addr = a; wr_data = d; wr_be = be;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic rd(logic [3:0] a);
    rd_en = 1'b1; wr_en = 1'b0; rd_addr = a;
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    #1;
    // Clear phase with a read held pending throughout.
    en = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
    do_reset();
    repeat (16) begin
      chk("clear_no_valid_a", 32'(rd_valid_a), 32'd0);
      cycle();
    end
    chk("busy_fell_a", 32'(busy_a), 32'd0);
    cycle();
    chk("first_read_valid_a", 32'(rd_valid_a), 32'd1);
    chk("first_read_data_a", rd_data_a, 32'h0);
    rd_en = 1'b0;
    cycle();

    // Byte-enable merge.
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    chk("be_merge_a", rd_data_a, 32'hAA22CC44);
    cycle();
    chk("be_merge_b", rd_data_b, 32'hAA22CC44);

    // Read-during-write on addr 7.
    wr(4'd7, 32'h0, 4'b1111);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd7;
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_old_a", rd_data_a, 32'h0);
    cycle();
    chk("rdw_new_b", rd_data_b, 32'hFFFFFFFF);

    // Streaming reads, mem[i] = i+1.
    for (int i = 0; i < 4; i++) wr(4'(i), 32'(i + 1), 4'b1111);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      cycle();
    end
    rd_en = 1'b0;
    repeat (3) cycle();

    // Out-of-range for the 12-deep instance.
    wr(4'd13, 32'h55, 4'b1111);
    cycle();
    chk("oor_wr_err_b", 32'(addr_err_b), 32'd1);
    rd(4'd13);
    cycle();
    chk("oor_rd_data_b", rd_data_b, 32'h0);
    chk("oor_rd_err_b", 32'(addr_err_b), 32'd1);
    chk("oor_rd_data_a", rd_data_a, 32'h55);
    wr_en = 1'b1; wr_addr = 4'd14; rd_en = 1'b1; rd_addr = 4'd15;
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) cycle();

    // en low blocks acceptance.
    en = 1'b0;
    wr(4'd2, 32'hDEADBEEF, 4'b1111);
    rd(4'd2);
    en = 1'b1;
    rd(4'd2);
    repeat (2) cycle();

    // Reset one cycle after a read is accepted.
    for (int i = 0; i < 12; i++) wr(4'(i), $urandom, 4'b1111);
    rd(4'd3);
    do_reset();
    chk("midrst_no_valid_b", 32'(rd_valid_b), 32'd0);
    repeat (16) cycle();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      cycle();
    end
    rd_en = 1'b0;
    repeat (2) cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      en      = ($urandom_range(0, 7) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      cycle();
    end
    en = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
